// File: rtl/wb_xbar_pkg.sv
// wb_xbar_pkg: shared types and helpers for the wb_xbar_n crossbar.
//   state_t      access FSM states (IDLE/REQ/RESP)
//   clog2        constant-evaluable ceiling log2, used to size the timeout counter
//   DEF_*        default widths/port count used by wb_xbar_n parameters
package wb_xbar_pkg;

    localparam int unsigned DEF_NSUB = 3;
    localparam int unsigned DEF_AW   = 32;
    localparam int unsigned DEF_DW   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_xbar_decode.sv
// wb_xbar_decode: address window decoder for wb_xbar_n.
//   adr     in   AW    byte address to decode
//   hit_c   out  NSUB  one-hot window hit; overlapping windows resolve to the lowest index
//   miss_c  out  1     no window matched
// Window i matches when (adr & MASKS[i]) == BASES[i]. Purely combinational.
module wb_xbar_decode
    import wb_xbar_pkg::*;
#(
    parameter int unsigned        NSUB  = DEF_NSUB,
    parameter int unsigned        AW    = DEF_AW,
    parameter logic [NSUB*AW-1:0] BASES = '0,
    parameter logic [NSUB*AW-1:0] MASKS = '0
) (
    input  logic [AW-1:0]   adr,
    output logic [NSUB-1:0] hit_c,
    output logic            miss_c
);

    // Priority scan: the first matching window claims the access.
    always_comb begin
        logic found;
        found = 1'b0;
        hit_c = '0;
        for (int i = 0; i < int'(NSUB); i++) begin
            if (!found && ((adr & MASKS[i*AW +: AW]) == BASES[i*AW +: AW])) begin
                hit_c[i] = 1'b1;
                found    = 1'b1;
            end
        end
        miss_c = !found;
    end

endmodule

// File: rtl/wb_xbar_n.sv
// wb_xbar_n: one pipelined Wishbone slave port fanned out to NSUB Wishbone master
// ports, each owning a base/mask address window. One access in flight.
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   s_cyc_i/s_stb_i/s_we_i          slave request
//   s_adr_i, s_dat_i, s_sel_i       slave address, write data, byte selects
//   s_ack_o, s_err_o                single-cycle response strobes
//   s_stall_o                       slave pipeline stall
//   s_dat_o                         read data, valid with s_ack_o
//   m_cyc_o, m_stb_o                per-submap request (one-hot)
//   m_we_o, m_adr_o, m_dat_o, m_sel_o  shared towards all submaps (full byte address)
//   m_dat_i                         submap read data, submap i at [i*DW +: DW]
//   m_ack_i, m_err_i                per-submap responses
// Decode misses answer with s_err_o; dropping s_cyc_i while a submap is being
// asked aborts the access without a slave response.
// Optional: define WB_XBAR_TIMEOUT_EN to force an error when a submap stays
// silent for TIMEOUT request cycles; otherwise the request waits indefinitely.
module wb_xbar_n
    import wb_xbar_pkg::*;
#(
    parameter int unsigned        NSUB    = DEF_NSUB,
    parameter int unsigned        AW      = DEF_AW,
    parameter int unsigned        DW      = DEF_DW,
    parameter logic [NSUB*AW-1:0] BASES   = '0,
    parameter logic [NSUB*AW-1:0] MASKS   = '0,
    parameter int unsigned        TIMEOUT = 255,
    localparam int unsigned       SW      = DW / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_cyc_i,
    input  logic                 s_stb_i,
    input  logic                 s_we_i,
    input  logic [AW-1:0]        s_adr_i,
    input  logic [DW-1:0]        s_dat_i,
    input  logic [SW-1:0]        s_sel_i,
    output logic                 s_ack_o,
    output logic                 s_err_o,
    output logic                 s_stall_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [NSUB-1:0]      m_cyc_o,
    output logic [NSUB-1:0]      m_stb_o,
    output logic                 m_we_o,
    output logic [AW-1:0]        m_adr_o,
    output logic [DW-1:0]        m_dat_o,
    output logic [SW-1:0]        m_sel_o,
    input  logic [NSUB*DW-1:0]   m_dat_i,
    input  logic [NSUB-1:0]      m_ack_i,
    input  logic [NSUB-1:0]      m_err_i
);

    state_t            state_q, state_d;
    logic [NSUB-1:0]   hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdat_q, rdat_d;

    logic              we_d;
    logic [AW-1:0]     adr_d;
    logic [DW-1:0]     wdat_d;
    logic [SW-1:0]     sel_d;
    logic [NSUB-1:0]   mcyc_d;
    logic              stall_d;
    logic              ack_d;
    logic              serr_d;
    logic [DW-1:0]     sdat_d;

    logic [NSUB-1:0]   dec_hit_c;
    logic              dec_miss_c;
    logic              sel_ack_c;
    logic              sel_err_c;
    logic [DW-1:0]     sel_dat_c;
    logic              tmo_hit_c;

    wb_xbar_decode #(
        .NSUB  (NSUB),
        .AW    (AW),
        .BASES (BASES),
        .MASKS (MASKS)
    ) u_decode (
        .adr    (s_adr_i),
        .hit_c  (dec_hit_c),
        .miss_c (dec_miss_c)
    );

    // Response of the selected submap only; other submaps are ignored.
    assign sel_ack_c = |(m_ack_i & hit_q);
    assign sel_err_c = |(m_err_i & hit_q);

    always_comb begin
        sel_dat_c = '0;
        for (int i = 0; i < int'(NSUB); i++) begin
            if (hit_q[i]) begin
                sel_dat_c = sel_dat_c | m_dat_i[i*DW +: DW];
            end
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    localparam int unsigned TW = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] tmo_cnt_q;

    // Held at zero outside REQ, so every access starts counting from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ST_REQ) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
    end

    // True in the TIMEOUT-th REQ cycle.
    assign tmo_hit_c = (state_q == ST_REQ) && (tmo_cnt_q == TW'(TIMEOUT - 1));
`else
    logic unused_tmo_c;
    assign unused_tmo_c = ^TIMEOUT;
    assign tmo_hit_c    = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hit_q     <= '0;
            miss_q    <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            m_we_o    <= 1'b0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            m_sel_o   <= '0;
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            s_stall_o <= 1'b0;
            s_ack_o   <= 1'b0;
            s_err_o   <= 1'b0;
            s_dat_o   <= '0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            m_we_o    <= we_d;
            m_adr_o   <= adr_d;
            m_dat_o   <= wdat_d;
            m_sel_o   <= sel_d;
            m_cyc_o   <= mcyc_d;
            m_stb_o   <= mcyc_d;
            s_stall_o <= stall_d;
            s_ack_o   <= ack_d;
            s_err_o   <= serr_d;
            s_dat_o   <= sdat_d;
        end
    end

    // Next state and next register values. The slave response is loaded while
    // in RESP, so it strobes during the first IDLE cycle that follows.
    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        we_d    = m_we_o;
        adr_d   = m_adr_o;
        wdat_d  = m_dat_o;
        sel_d   = m_sel_o;
        mcyc_d  = '0;
        stall_d = 1'b0;
        ack_d   = 1'b0;
        serr_d  = 1'b0;
        sdat_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    hit_d   = dec_hit_c;
                    miss_d  = dec_miss_c;
                    err_d   = 1'b0;
                    rdat_d  = '0;
                    we_d    = s_we_i;
                    adr_d   = s_adr_i;
                    wdat_d  = s_dat_i;
                    sel_d   = s_sel_i;
                    stall_d = 1'b1;
                    if (dec_miss_c) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                        mcyc_d  = dec_hit_c;
                    end
                end
            end

            ST_REQ: begin
                stall_d = 1'b1;
                if (!s_cyc_i) begin
                    // Host abandoned the cycle: release the submap, no response.
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                end else if (sel_ack_c || sel_err_c) begin
                    err_d   = sel_err_c;
                    rdat_d  = sel_dat_c;
                    state_d = ST_RESP;
                end else if (tmo_hit_c) begin
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    state_d = ST_RESP;
                end else begin
                    mcyc_d = hit_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                ack_d   = !(err_q || miss_q);
                serr_d  = err_q || miss_q;
                sdat_d  = (m_we_o || err_q || miss_q) ? '0 : rdat_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_xbar_n.sv
// tb_wb_xbar_n: randomized self-checking bench for wb_xbar_n (NSUB=3).
// Each access is planned up front as a per-cycle timeline of expected outputs
// derived from the window rules and the documented latencies; the submap
// responders replay the planned responses and one compare process checks the
// DUT against the timeline every cycle. Directed accesses add literal checks.
module tb_wb_xbar_n;

    localparam int unsigned NSUB  = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int          TMO   = 8;
    localparam int          DEPTH = 4096;

    localparam logic [NSUB*AW-1:0] BASES = {32'h0002_0000, 32'h0000_4000, 32'h0000_0000};
    localparam logic [NSUB*AW-1:0] MASKS = {32'h0002_0000, 32'h0000_C000, 32'h0000_C000};

    logic              clk;
    logic              rst;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat;
    logic [SW-1:0]     s_sel;
    logic              s_ack_o, s_err_o, s_stall_o;
    logic [DW-1:0]     s_dat_o;
    logic [NSUB-1:0]   m_cyc_o, m_stb_o;
    logic              m_we_o;
    logic [AW-1:0]     m_adr_o;
    logic [DW-1:0]     m_dat_o;
    logic [SW-1:0]     m_sel_o;
    logic [NSUB*DW-1:0] m_dat;
    logic [NSUB-1:0]   m_ack, m_err;

    wb_xbar_n #(
        .NSUB    (NSUB),
        .AW      (AW),
        .DW      (DW),
        .BASES   (BASES),
        .MASKS   (MASKS),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_cyc_i   (s_cyc),
        .s_stb_i   (s_stb),
        .s_we_i    (s_we),
        .s_adr_i   (s_adr),
        .s_dat_i   (s_dat),
        .s_sel_i   (s_sel),
        .s_ack_o   (s_ack_o),
        .s_err_o   (s_err_o),
        .s_stall_o (s_stall_o),
        .s_dat_o   (s_dat_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_sel_o   (m_sel_o),
        .m_dat_i   (m_dat),
        .m_ack_i   (m_ack),
        .m_err_i   (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline indexed by cycle number (posedges seen so far).
    bit [2:0]  exp_mcyc  [DEPTH];
    bit        exp_stall [DEPTH];
    bit        exp_ack   [DEPTH];
    bit        exp_err   [DEPTH];
    bit [31:0] exp_dat   [DEPTH];
    bit        exp_we    [DEPTH];
    bit [31:0] exp_adr   [DEPTH];
    bit [31:0] exp_wdat  [DEPTH];
    bit [3:0]  exp_sel   [DEPTH];
    bit [2:0]  ack_plan  [DEPTH];
    bit [2:0]  err_plan  [DEPTH];
    int        datk_plan [DEPTH];
    bit [31:0] dat_plan  [DEPTH];

    int cyc_n  = 0;
    bit cmp_en = 1'b0;
    int n_chk  = 0;
    int n_pass = 0;

    // Monitor accumulators for directed literal checks.
    int        ack_cnt, err_cnt, ack_n, err_n;
    bit [31:0] ack_dat, err_dat, wdat_seen;
    bit [2:0]  mcyc_seen;
    bit        we_seen;
    bit [3:0]  sel_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h want 0x%0h", name, cyc_n, act, exp);
    endtask

    // Window rules written out directly: lowest matching window wins.
    function automatic int model_target(input logic [31:0] a);
        if ((a & 32'h0000_C000) == 32'h0000_0000) return 0;
        if ((a & 32'h0000_C000) == 32'h0000_4000) return 1;
        if ((a & 32'h0002_0000) == 32'h0002_0000) return 2;
        return -1;
    endfunction

    task automatic mon_clear();
        ack_cnt = 0; err_cnt = 0; ack_n = -1; err_n = -1;
        ack_dat = '0; err_dat = '0; wdat_seen = '0;
        mcyc_seen = '0; we_seen = 1'b0; sel_seen = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Submap responders replay the plan; read data on idle lanes is random.
    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        #1;
        if (cyc_n < DEPTH) begin
            m_ack = ack_plan[cyc_n];
            m_err = err_plan[cyc_n];
            for (int i = 0; i < 3; i++) m_dat[i*32 +: 32] = $urandom;
            if (datk_plan[cyc_n] >= 0) m_dat[datk_plan[cyc_n]*32 +: 32] = dat_plan[cyc_n];
        end else begin
            m_ack = '0;
            m_err = '0;
        end
    end

    // Compare process plus monitor.
    always @(negedge clk) begin
        int n;
        n = cyc_n;
        if (s_ack_o) begin ack_cnt++; ack_dat = s_dat_o; if (ack_n < 0) ack_n = n; end
        if (s_err_o) begin err_cnt++; err_dat = s_dat_o; if (err_n < 0) err_n = n; end
        mcyc_seen = mcyc_seen | m_cyc_o;
        if (m_cyc_o != 0) begin
            we_seen = we_seen | m_we_o;
            wdat_seen = m_dat_o;
            sel_seen = m_sel_o;
        end
        if (cmp_en && n < DEPTH) begin
            chk("m_cyc_o", 32'(m_cyc_o), 32'(exp_mcyc[n]));
            chk("m_stb_o", 32'(m_stb_o), 32'(exp_mcyc[n]));
            chk("s_stall_o", 32'(s_stall_o), 32'(exp_stall[n]));
            chk("s_ack_o", 32'(s_ack_o), 32'(exp_ack[n]));
            chk("s_err_o", 32'(s_err_o), 32'(exp_err[n]));
            if (exp_ack[n] || exp_err[n]) chk("s_dat_o", s_dat_o, exp_dat[n]);
            if (exp_mcyc[n] != 0) begin
                chk("m_we_o", 32'(m_we_o), 32'(exp_we[n]));
                chk("m_adr_o", m_adr_o, exp_adr[n]);
                chk("m_dat_o", m_dat_o, exp_wdat[n]);
                chk("m_sel_o", 32'(m_sel_o), 32'(exp_sel[n]));
            end
        end
    end

    // Plans one access, drives it and returns after its last meaningful cycle.
    // abort_d >= 0: drop s_cyc after abort_d REQ cycles (no ack planned).
    // tmo: selected submap stays silent for lat+1 REQ cycles, error expected.
    task automatic do_access(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [3:0] sel, input int lat, input bit rerr,
                             input logic [31:0] rdat, input int abort_d, input bit resp_drop,
                             input bit tmo, output int n0);
        int k, last, rn;
        k    = model_target(adr);
        n0   = cyc_n + 1;
        rn   = -1;
        last = n0;
        if (k < 0) begin
            exp_stall[n0] = 1'b1;
            rn = n0 + 1;
            exp_err[rn] = 1'b1;
            exp_dat[rn] = '0;
        end else begin
            last = (abort_d >= 0) ? n0 + abort_d : n0 + lat;
            for (int n = n0; n <= last; n++) begin
                exp_mcyc[n]  = 3'(1 << k);
                exp_we[n]    = we;
                exp_adr[n]   = adr;
                exp_wdat[n]  = wdat;
                exp_sel[n]   = sel;
                exp_stall[n] = 1'b1;
                ack_plan[n]  = 3'($urandom) & ~exp_mcyc[n];
                err_plan[n]  = 3'($urandom) & ~exp_mcyc[n];
            end
            if (abort_d < 0) begin
                if (!tmo) begin
                    if (rerr) begin
                        err_plan[last][k] = 1'b1;
                        ack_plan[last][k] = 1'($urandom);
                    end else begin
                        ack_plan[last][k] = 1'b1;
                    end
                    datk_plan[last] = k;
                    dat_plan[last]  = rdat;
                end
                exp_stall[last + 1] = 1'b1;
                rn = last + 2;
                if (rerr || tmo) begin
                    exp_err[rn] = 1'b1;
                    exp_dat[rn] = '0;
                end else begin
                    exp_ack[rn] = 1'b1;
                    exp_dat[rn] = we ? 32'h0 : rdat;
                end
            end
        end
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_dat = wdat; s_sel = sel;
        step();
        s_stb = 1'b0;
        if (rn < 0) begin
            while (cyc_n < last) step();
            s_cyc = 1'b0;
            step();
        end else begin
            while (cyc_n < rn - 1) step();
            if (resp_drop) s_cyc = 1'b0;
            while (cyc_n < rn) step();
            s_cyc = 1'b0;
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_adr = '0; s_dat = '0; s_sel = '0;
        m_ack = '0; m_err = '0; m_dat = '0;
        for (int i = 0; i < DEPTH; i++) datk_plan[i] = -1;
        mon_clear();

        // Reset values.
        repeat (2) step();
        chk("rst s_stall_o", 32'(s_stall_o), 32'h0);
        chk("rst m_cyc_o", 32'(m_cyc_o), 32'h0);
        chk("rst s_ack_o", 32'(s_ack_o), 32'h0);
        chk("rst s_err_o", 32'(s_err_o), 32'h0);
        chk("rst m_adr_o", m_adr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 cmp_en = 1'b1;
        step();

        // Pin the decode model to the window table.
        chk("model 0x4010", 32'(model_target(32'h4010)), 32'd1);
        chk("model 0x20004", 32'(model_target(32'h20004)), 32'd0);
        chk("model 0x28004", 32'(model_target(32'h28004)), 32'd2);
        chk("model 0x8000", 32'(model_target(32'h8000)), 32'hFFFF_FFFF);

        // Read from sub1, ack three cycles into the request.
        mon_clear();
        do_access(1'b0, 32'h4010, 32'h0, 4'hF, 3, 1'b0, 32'hCAFE0001, -1, 1'b0, 1'b0, n0);
        step();
        chk("rd1 ack count", 32'(ack_cnt), 32'd1);
        chk("rd1 err count", 32'(err_cnt), 32'd0);
        chk("rd1 data", ack_dat, 32'hCAFE0001);
        chk("rd1 cyc seen", 32'(mcyc_seen), 32'h2);

        // 0x20004 also sits in window 0, which wins by priority.
        mon_clear();
        do_access(1'b1, 32'h20004, 32'hA5A5A5A5, 4'h3, 1, 1'b0, 32'h0, -1, 1'b0, 1'b0, n0);
        step();
        chk("wr0 ack count", 32'(ack_cnt), 32'd1);
        chk("wr0 err count", 32'(err_cnt), 32'd0);
        chk("wr0 we seen", 32'(we_seen), 32'h1);
        chk("wr0 wdat", wdat_seen, 32'hA5A5A5A5);
        chk("wr0 sel", 32'(sel_seen), 32'h3);
        chk("wr0 cyc seen", 32'(mcyc_seen), 32'h1);

        // Write that only window 2 claims.
        mon_clear();
        do_access(1'b1, 32'h28004, 32'hA5A5A5A5, 4'h3, 2, 1'b0, 32'h0, -1, 1'b0, 1'b0, n0);
        step();
        chk("wr2 ack count", 32'(ack_cnt), 32'd1);
        chk("wr2 cyc seen", 32'(mcyc_seen), 32'h4);
        chk("wr2 ack data", ack_dat, 32'h0);

        // Unmapped read.
        mon_clear();
        do_access(1'b0, 32'h8000, 32'h0, 4'hF, 0, 1'b0, 32'h0, -1, 1'b0, 1'b0, n0);
        step();
        chk("miss cyc seen", 32'(mcyc_seen), 32'h0);
        chk("miss err count", 32'(err_cnt), 32'd1);
        chk("miss ack count", 32'(ack_cnt), 32'd0);
        chk("miss latency", 32'(err_n - (n0 - 1)), 32'd2);
        chk("miss data", err_dat, 32'h0);

        // Sub0 signals an error.
        mon_clear();
        do_access(1'b0, 32'h0100, 32'h0, 4'hF, 1, 1'b1, 32'h5555AAAA, -1, 1'b0, 1'b0, n0);
        step();
        chk("serr err count", 32'(err_cnt), 32'd1);
        chk("serr ack count", 32'(ack_cnt), 32'd0);

        // Host drops s_cyc one cycle into the request, then a normal access.
        mon_clear();
        do_access(1'b0, 32'h4000, 32'h0, 4'hF, 5, 1'b0, 32'h0, 1, 1'b0, 1'b0, n0);
        step();
        chk("abort ack count", 32'(ack_cnt), 32'd0);
        chk("abort err count", 32'(err_cnt), 32'd0);
        mon_clear();
        do_access(1'b0, 32'h0004, 32'h0, 4'hF, 0, 1'b0, 32'h0BADF00D, -1, 1'b0, 1'b0, n0);
        step();
        chk("post-abort ack count", 32'(ack_cnt), 32'd1);
        chk("post-abort data", ack_dat, 32'h0BADF00D);

        // s_cyc low while the response is pending: response still arrives.
        mon_clear();
        do_access(1'b0, 32'h4020, 32'h0, 4'hF, 1, 1'b0, 32'h12345678, -1, 1'b1, 1'b0, n0);
        step();
        chk("respdrop ack count", 32'(ack_cnt), 32'd1);
        chk("respdrop data", ack_dat, 32'h12345678);

        // Silent submap.
        mon_clear();
`ifdef WB_XBAR_TIMEOUT_EN
        do_access(1'b0, 32'h4040, 32'h0, 4'hF, TMO - 1, 1'b0, 32'h0, -1, 1'b0, 1'b1, n0);
        step();
        chk("tmo err count", 32'(err_cnt), 32'd1);
        chk("tmo err cycle", 32'(err_n - n0), 32'(TMO + 1));
        mon_clear();
        do_access(1'b0, 32'h4044, 32'h0, 4'hF, TMO - 1, 1'b0, 32'h600DCAFE, -1, 1'b0, 1'b0, n0);
        step();
        chk("tmo-edge ack count", 32'(ack_cnt), 32'd1);
        chk("tmo-edge data", ack_dat, 32'h600DCAFE);
`else
        do_access(1'b0, 32'h4040, 32'h0, 4'hF, 0, 1'b0, 32'h0, 40, 1'b0, 1'b0, n0);
        step();
        chk("silent err count", 32'(err_cnt), 32'd0);
        chk("silent ack count", 32'(ack_cnt), 32'd0);
`endif

        // Randomized traffic.
        for (int t = 0; t < 150 && cyc_n < DEPTH - 120; t++) begin
            bit          we, rerr, rdrop;
            logic [31:0] adr;
            int          lat, ab;
            we    = 1'($urandom);
            adr   = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'h0003_FFFC);
            lat   = $urandom % 5;
            rerr  = ($urandom % 6 == 0);
            rdrop = ($urandom % 4 == 0);
            ab    = -1;
            if ($urandom % 6 == 0 && lat > 0) ab = $urandom % lat;
            do_access(we, adr, $urandom, 4'($urandom), lat, rerr, $urandom, ab, rdrop, 1'b0, n0);
            repeat ($urandom % 3) step();
        end

        // Asynchronous reset while a request is outstanding.
        cmp_en = 1'b0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 32'h4010;
        s_dat = 32'hDEADBEEF; s_sel = 4'hF;
        step();
        s_stb = 1'b0;
        step();
        chk("pre-reset m_cyc_o", 32'(m_cyc_o), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("arst m_cyc_o", 32'(m_cyc_o), 32'h0);
        chk("arst m_stb_o", 32'(m_stb_o), 32'h0);
        chk("arst s_stall_o", 32'(s_stall_o), 32'h0);
        chk("arst m_we_o", 32'(m_we_o), 32'h0);
        chk("arst m_adr_o", m_adr_o, 32'h0);
        chk("arst m_dat_o", m_dat_o, 32'h0);
        chk("arst m_sel_o", 32'(m_sel_o), 32'h0);
        chk("arst s_ack_o", 32'(s_ack_o), 32'h0);
        chk("arst s_err_o", 32'(s_err_o), 32'h0);
        chk("arst s_dat_o", s_dat_o, 32'h0);
        s_cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        cmp_en = 1'b1;
        mon_clear();
        do_access(1'b0, 32'h4018, 32'h0, 4'hF, 2, 1'b0, 32'h77665544, -1, 1'b0, 1'b0, n0);
        step();
        chk("post-rst ack count", 32'(ack_cnt), 32'd1);
        chk("post-rst data", ack_dat, 32'h77665544);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
